// File: rtl/hangman_pkg.sv
// Shared state encoding, ASCII bounds and default sizing for the hangman round controller.
package hangman_pkg;

  localparam int DEFAULT_WORD_LEN     = 5;
  localparam int DEFAULT_MAX_MISTAKES = 6;

  localparam logic [7:0] ASCII_A = 8'd65;
  localparam logic [7:0] ASCII_Z = 8'd90;

  typedef enum logic [2:0] {
    ST_SETUP,
    ST_GUESS,
    ST_CHECK,
    ST_SEND,
    ST_WIN,
    ST_LOSE
  } state_t;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/hangman_letter_match.sv
// Combinational compare of the guess against every stored letter of the secret word.
module hangman_letter_match
  import hangman_pkg::*;
#(
  parameter int WORD_LEN = DEFAULT_WORD_LEN
) (
  input  logic [WORD_LEN*8-1:0] word,
  input  logic [7:0]            guess,
  output logic [WORD_LEN-1:0]   hit
);

  for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_pos
    assign hit[gi] = (word[gi*8 +: 8] == guess);
  end

endmodule

// File: rtl/hangman_round_ctrl.sv
// Hangman round controller: secret-word entry, guess checking, guess transmission, win/lose tracking.
// Build option HANGMAN_REPEAT_FILTER_EN: letters already guessed this round are dropped in GUESS.
module hangman_round_ctrl
  import hangman_pkg::*;
#(
  parameter int WORD_LEN     = DEFAULT_WORD_LEN,
  parameter int MAX_MISTAKES = DEFAULT_MAX_MISTAKES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                letter_valid,
  input  logic [7:0]          letter,
  input  logic                word_submit,
  input  logic                game_end,
  input  logic                tx_ready,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  output logic [WORD_LEN-1:0] correct_mask,
  output logic [2:0]          mistakes,
  output logic                win,
  output logic                lose,
  output logic                setup_mode
);

  localparam int               IDX_W    = $clog2(WORD_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(WORD_LEN);
  localparam logic [2:0]       MIST_MAX = 3'(MAX_MISTAKES);

  state_t                   state_reg, state_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic [WORD_LEN-1:0][7:0] word_reg, word_next;
  logic [7:0]               guess_reg, guess_next;
  logic [WORD_LEN-1:0]      mask_reg, mask_next;
  logic [2:0]               mistakes_reg, mistakes_next;
  logic [WORD_LEN-1:0]      hit;
  logic                     letter_ok;
  logic                     word_full;
  logic                     clear_round;

`ifdef HANGMAN_REPEAT_FILTER_EN
  logic [25:0] guessed_reg, guessed_next;
  logic [4:0]  letter_ofs;

  assign letter_ofs = 5'(letter - ASCII_A);
`endif

  assign letter_ok = letter_valid && is_letter(letter);
  assign word_full = (idx_reg == IDX_FULL);

  hangman_letter_match #(
    .WORD_LEN(WORD_LEN)
  ) u_match (
    .word  (word_reg),
    .guess (guess_reg),
    .hit   (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_SETUP;
      idx_reg      <= '0;
      word_reg     <= '0;
      guess_reg    <= '0;
      mask_reg     <= '0;
      mistakes_reg <= '0;
`ifdef HANGMAN_REPEAT_FILTER_EN
      guessed_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      word_reg     <= word_next;
      guess_reg    <= guess_next;
      mask_reg     <= mask_next;
      mistakes_reg <= mistakes_next;
`ifdef HANGMAN_REPEAT_FILTER_EN
      guessed_reg  <= guessed_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    word_next     = word_reg;
    guess_next    = guess_reg;
    mask_next     = mask_reg;
    mistakes_next = mistakes_reg;
    clear_round   = 1'b0;
`ifdef HANGMAN_REPEAT_FILTER_EN
    guessed_next  = guessed_reg;
`endif

    case (state_reg)
      ST_SETUP: begin
        // A complete word lets submit win over a coincident letter, which is dropped anyway.
        if (word_submit && word_full) begin
          state_next    = ST_GUESS;
          mask_next     = '0;
          mistakes_next = '0;
`ifdef HANGMAN_REPEAT_FILTER_EN
          guessed_next  = '0;
`endif
        end else if (letter_ok && !word_full) begin
          for (int i = 0; i < WORD_LEN; i++) begin
            if (idx_reg == IDX_W'(i)) word_next[i] = letter;
          end
          idx_next = idx_reg + 1'b1;
        end
      end

      ST_GUESS: begin
`ifdef HANGMAN_REPEAT_FILTER_EN
        if (letter_ok && !guessed_reg[letter_ofs]) begin
          guessed_next[letter_ofs] = 1'b1;
          guess_next               = letter;
          state_next               = ST_CHECK;
        end
`else
        if (letter_ok) begin
          guess_next = letter;
          state_next = ST_CHECK;
        end
`endif
      end

      ST_CHECK: begin
        mask_next = mask_reg | hit;
        if ((hit == '0) && (mistakes_reg < MIST_MAX)) mistakes_next = mistakes_reg + 3'd1;
        state_next = ST_SEND;
      end

      ST_SEND: begin
        if (tx_ready) begin
          if (&mask_reg)                     state_next = ST_WIN;
          else if (mistakes_reg == MIST_MAX) state_next = ST_LOSE;
          else                               state_next = ST_GUESS;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (word_submit) clear_round = 1'b1;
      end

      default: state_next = ST_SETUP;
    endcase

    // Abort overrides whatever the state logic decided this cycle.
    if (game_end || clear_round) begin
      state_next    = ST_SETUP;
      idx_next      = '0;
      word_next     = '0;
      guess_next    = '0;
      mask_next     = '0;
      mistakes_next = '0;
`ifdef HANGMAN_REPEAT_FILTER_EN
      guessed_next  = '0;
`endif
    end
  end

  // tx_valid is cut combinationally so an abort or reset never completes a pending transfer.
  assign tx_valid     = (state_reg == ST_SEND) && !game_end && !rst;
  assign tx_data      = guess_reg;
  assign correct_mask = mask_reg;
  assign mistakes     = mistakes_reg;
  assign win          = (state_reg == ST_WIN);
  assign lose         = (state_reg == ST_LOSE);
  assign setup_mode   = (state_reg == ST_SETUP);

endmodule
